// File: rtl/vga_timing_gen.sv
// 640x480@60 raster timing: pixel-rate divider, h/v counters, registered addresses and blanked RGB/sync.
// Optional colour-bar generator enabled by defining VGA_TEST_PATTERN_EN (adds the test_mode port).
module vga_timing_gen #(
   parameter int unsigned CLK_DIV   = 4,
   parameter int unsigned H_VISIBLE = 640,
   parameter int unsigned H_FP      = 16,
   parameter int unsigned H_SYNC    = 96,
   parameter int unsigned H_BP      = 48,
   parameter int unsigned V_VISIBLE = 480,
   parameter int unsigned V_FP      = 10,
   parameter int unsigned V_SYNC    = 2,
   parameter int unsigned V_BP      = 33,
   parameter bit          SYNC_POL  = 1'b0
) (
   input  logic        clk,
   input  logic        reset,
`ifdef VGA_TEST_PATTERN_EN
   input  logic        test_mode,
`endif
   input  logic [11:0] c_in,
   output logic [9:0]  addr_x,
   output logic [8:0]  addr_y,
   output logic        pixel_en,
   output logic        frame_start,
   output logic [11:0] colour_out,
   output logic        hs,
   output logic        vs
);

   localparam int unsigned H_TOTAL = H_VISIBLE + H_FP + H_SYNC + H_BP;
   localparam int unsigned V_TOTAL = V_VISIBLE + V_FP + V_SYNC + V_BP;
   localparam int unsigned DIV_W   = $clog2(CLK_DIV);

   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
   localparam logic [9:0] H_LAST     = 10'(H_TOTAL - 1);
   localparam logic [9:0] V_LAST     = 10'(V_TOTAL - 1);
   localparam logic [9:0] H_VIS      = 10'(H_VISIBLE);
   localparam logic [9:0] V_VIS      = 10'(V_VISIBLE);
   localparam logic [9:0] HS_START   = 10'(H_VISIBLE + H_FP);
   localparam logic [9:0] HS_END     = 10'(H_VISIBLE + H_FP + H_SYNC);
   localparam logic [9:0] VS_START   = 10'(V_VISIBLE + V_FP);
   localparam logic [9:0] VS_END     = 10'(V_VISIBLE + V_FP + V_SYNC);
`ifdef VGA_TEST_PATTERN_EN
   localparam logic [9:0] BAR_W      = 10'(H_VISIBLE / 8);
`endif

   logic [DIV_W-1:0] div_cnt_q, div_cnt_d;
   logic [9:0]       h_cnt_q, h_cnt_d;
   logic [9:0]       v_cnt_q, v_cnt_d;
   logic [9:0]       addr_x_q, addr_x_d;
   logic [8:0]       addr_y_q, addr_y_d;
   logic [11:0]      colour_q, colour_d;
   logic             hs_q, hs_d;
   logic             vs_q, vs_d;
   logic             pix_en;
   logic             h_wrap;
   logic             v_wrap;
   logic             de;
   logic [11:0]      vis_colour;
`ifdef VGA_TEST_PATTERN_EN
   logic [2:0]       bar_idx;
   logic [11:0]      bar_colour;
`endif

`ifdef VGA_TEST_PATTERN_EN
   always_comb begin
      bar_idx = 3'(h_cnt_q / BAR_W);
      case (bar_idx)
         3'd0:    bar_colour = 12'hFFF;
         3'd1:    bar_colour = 12'hFF0;
         3'd2:    bar_colour = 12'h0FF;
         3'd3:    bar_colour = 12'h0F0;
         3'd4:    bar_colour = 12'hF0F;
         3'd5:    bar_colour = 12'hF00;
         3'd6:    bar_colour = 12'h00F;
         default: bar_colour = 12'h000;
      endcase
      vis_colour = test_mode ? bar_colour : c_in;
   end
`else
   always_comb vis_colour = c_in;
`endif

   always_comb begin
      pix_en    = (div_cnt_q == DIV_LAST);
      // >= rather than == so an upset counter falls back to 0 instead of running on
      div_cnt_d = (div_cnt_q >= DIV_LAST) ? '0 : div_cnt_q + 1'b1;
      h_wrap    = (h_cnt_q >= H_LAST);
      v_wrap    = (v_cnt_q >= V_LAST);
      de        = (h_cnt_q < H_VIS) && (v_cnt_q < V_VIS);

      h_cnt_d   = h_cnt_q;
      v_cnt_d   = v_cnt_q;
      addr_x_d  = addr_x_q;
      addr_y_d  = addr_y_q;
      colour_d  = colour_q;
      hs_d      = hs_q;
      vs_d      = vs_q;

      if (pix_en) begin
         h_cnt_d = h_wrap ? '0 : h_cnt_q + 10'd1;
         if (h_wrap) begin
            v_cnt_d = v_wrap ? '0 : v_cnt_q + 10'd1;
         end
         addr_x_d = (h_cnt_d < H_VIS) ? h_cnt_d : '0;
         addr_y_d = (v_cnt_d < V_VIS) ? v_cnt_d[8:0] : '0;
         // output stage uses the pre-advance counters, so it trails the address by one pixel
         colour_d = de ? vis_colour : 12'h000;
         hs_d     = ((h_cnt_q >= HS_START) && (h_cnt_q < HS_END)) ? SYNC_POL : ~SYNC_POL;
         vs_d     = ((v_cnt_q >= VS_START) && (v_cnt_q < VS_END)) ? SYNC_POL : ~SYNC_POL;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         div_cnt_q <= '0;
         h_cnt_q   <= '0;
         v_cnt_q   <= '0;
         addr_x_q  <= '0;
         addr_y_q  <= '0;
         colour_q  <= '0;
         hs_q      <= ~SYNC_POL;
         vs_q      <= ~SYNC_POL;
      end else begin
         div_cnt_q <= div_cnt_d;
         h_cnt_q   <= h_cnt_d;
         v_cnt_q   <= v_cnt_d;
         addr_x_q  <= addr_x_d;
         addr_y_q  <= addr_y_d;
         colour_q  <= colour_d;
         hs_q      <= hs_d;
         vs_q      <= vs_d;
      end
   end

   assign pixel_en    = pix_en;
   assign frame_start = pix_en && (h_cnt_q == H_LAST) && (v_cnt_q == V_LAST);
   assign addr_x      = addr_x_q;
   assign addr_y      = addr_y_q;
   assign colour_out  = colour_q;
   assign hs          = hs_q;
   assign vs          = vs_q;

endmodule
